xd_pulse_sched: RTL
===================

Name: xd_pulse_sched

Overview:
- Source-domain scheduler that shares a single toggle-based pulse crossing channel between N requesters.
- Counts each requester's event pulses and grants requesters round-robin.
- Emits one single-cycle pulse per grant toward the crossing, with a guaranteed minimum spacing so the destination shift register resolves every toggle.
- Holds the granted requester index stable on id_o, so the destination can sample it as quasi-static data when the crossed pulse arrives.

Parameters:
- N, 4: number of requesters; N >= 2.
- GAP, 8: minimum cycles between pulse_o assertions; GAP >= 2. Set from the clock ratio: at least 3 destination periods.
- CNT_W, 4: width of each requester's pending-event counter. Saturates at 2^CNT_W-1.

Ports:
- clk_i  input  1  source-domain clock.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  N  per-requester event pulses; any bit may be high on any cycle, and multiple bits may be high together.
- en_i  input  1  scheduler enable; new grants start only while high.
- pulse_o  output  1  single-cycle pulse to the crossing channel input.
- id_o  output  $clog2(N)  index of the most recent grant; stable between grants.
- busy_o  output  1  high while the FSM is not in IDLE.
- pend_o  output  N  bit k is high when counter k is nonzero.
- drop_o  output  N  bit k pulses for one cycle when a req_i[k] event is lost to saturation.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - All counters 0; state IDLE.
  - pulse_o 0, id_o 0, busy_o 0, pend_o 0, drop_o 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Reset mid-ISSUE or mid-GAP aborts immediately; pending counts are discarded.
- Counters, per requester k, every cycle:
  - Next value = cnt + req_i[k] - dec_k, where dec_k is high in the ISSUE cycle for the granted k.
  - req and dec in the same cycle leave the count unchanged.
  - If cnt is at max, req_i[k] is high and dec_k is low: count stays at max and drop_o[k] is 1 the next cycle.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE, when en_i=1 and any count is nonzero:
    - Select the first nonzero k, searching from ptr upward with wrap-around.
    - Register grant=k and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - pulse_o=1; id_o takes the value grant in this cycle.
    - Decrement count[grant]; ptr <= (grant+1) mod N.
    - Load gap counter with GAP-2; go to GAP.
  - GAP:
    - Decrement the gap counter; go to IDLE when it is 0.
    - Ignores en_i and req_i, which are still counted.
- Timing:
  - Rising edges of pulse_o are at least GAP cycles apart.
  - Under continuous backlog, exactly GAP cycles apart.
  - Latency: req_i[k] high in cycle t with an idle scheduler and an empty counter gives pulse_o=1 in cycle t+2 (t+1 counter visible/IDLE decision, t+2 ISSUE).
- Outputs:
  - pulse_o is high only in ISSUE; never high two consecutive cycles.
  - id_o changes only in the ISSUE cycle.
  - busy_o = (state != IDLE), registered with the state.
  - pend_o is derived combinationally from the counters.
- en_i deassert: the current ISSUE/GAP completes; the FSM then holds in IDLE. Counting continues. On reassert, arbitration resumes from the saved ptr.
- Fairness: a requester with a nonzero count is granted within N grants.

Test Plan:
- Reset release, then a single req_i=4'b0100 at cycle 10 -> pulse_o=1 at cycle 12 only, id_o=2 from cycle 12 onward, busy_o high cycles 12..12+GAP-2, pend_o[2] low from cycle 13.
- req_i=4'b1111 for one cycle -> four pulses, grant order 0,1,2,3, rising edges exactly GAP=8 cycles apart, id_o stable between them.
- Hold req_i[1]=1 for 20 cycles with en_i=0 -> count saturates at 15, drop_o[1] pulses for the 5 excess events; on en_i=1, exactly 15 pulses with id_o=1.
- Simultaneous req_i[0] during its own ISSUE decrement with count=1 -> count stays 1; the next grant still goes to 0 only after the other pending requesters (round-robin).
- Assert rst_i during GAP with counts {3,0,2,0} -> next cycle all outputs 0 and counts 0; the next request to k=3 is granted first with no backlog.
- Chain with xd at clk_o = clk_i/3 and GAP=9 -> destination sees exactly one output pulse per pulse_o, and id_o sampled at the destination pulse matches the grant.

Source files
------------

// File: rtl/xd_pulse_sched.sv
// Round-robin scheduler that shares one toggle-based pulse crossing between N requesters.
// Each requester has a saturating event counter. pulse_o is spaced at least GAP cycles apart.
module xd_pulse_sched #(
  parameter int unsigned N     = 4,
  parameter int unsigned GAP   = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 en_i,
  output logic                 pulse_o,
  output logic [$clog2(N)-1:0] id_o,
  output logic                 busy_o,
  output logic [N-1:0]         pend_o,
  output logic [N-1:0]         drop_o
);

  localparam int unsigned ID_W = $clog2(N);
  localparam int unsigned GW   = $clog2(GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pulse_q, pulse_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  logic             sel_found;
  logic [ID_W-1:0]  sel_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // First nonzero counter at or after ptr, wrapping around.
  always_comb begin
    int unsigned j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!sel_found && (cnt_q[j] != '0)) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (en_i && sel_found) begin
          grant_d = sel_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ptr_d = (32'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
        gap_d = GAP_LOAD;
        state_d = (GAP == 2) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    pulse_d = (state_d == S_ISSUE);
    id_d    = (state_d == S_ISSUE) ? grant_d : id_q;
    busy_d  = (state_d != S_IDLE);
  end

  // Per-requester counters: +req, -grant decrement, saturate with drop flag.
  always_comb begin
    logic dec;
    dec    = 1'b0;
    drop_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      dec      = (state_q == S_ISSUE) && (32'(grant_q) == k);
      cnt_d[k] = cnt_q[k];
      if (req_i[k] && !dec) begin
        if (cnt_q[k] == CNT_MAX) drop_d[k] = 1'b1;
        else                     cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (!req_i[k] && dec) begin
        cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) pend_o[k] = |cnt_q[k];
  end

  assign pulse_o = pulse_q;
  assign id_o    = id_q;
  assign busy_o  = busy_q;
  assign drop_o  = drop_q;

endmodule
